// File: rtl/and_sweep_pkg.sv
// -----------------------------------------------------------------------------
// and_sweep_pkg
//
// Shared definitions for the AND-datapath sweep sequencer:
//   - state_t   : sequencer FSM states (IDLE, APPLY, CHECK, HOLD, DONE)
//   - NUM_VEC   : number of input vectors swept (all combinations of A,B,C,D)
//   - VEC_W     : width of the vector index
//   - ERR_W     : width of the mismatch counter (holds 0..16)
//   - CNT_W     : width of the dwell counter (DWELL up to 255)
//   - exp_efg() : golden model of the datapath, returns {E, F, G}
//
// Optional feature macro used by files importing this package: FAIL_CAPTURE_EN.
// -----------------------------------------------------------------------------
package and_sweep_pkg;

    localparam int NUM_VEC = 16;
    localparam int VEC_W   = 4;
    localparam int ERR_W   = 5;
    localparam int CNT_W   = 8;

    // Index of the final vector; the FSM finishes the sweep here instead of
    // incrementing, so vec_idx never wraps.
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        CHECK = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Expected datapath outputs for a vector {A,B,C,D} = vec[3:0].
    function automatic logic [2:0] exp_efg(input logic [VEC_W-1:0] vec);
        logic ab;
        logic cd;
        ab = vec[3] & vec[2];
        cd = vec[1] & vec[0];
        return {ab, cd, ab & cd};
    endfunction

endpackage

// File: rtl/and_sweep_cnt.sv
// -----------------------------------------------------------------------------
// and_sweep_cnt
//
// Dwell counter for the sweep sequencer. Counts 0..DWELL-1 while enabled and
// wraps back to 0, so each wrap marks the start of the next vector period.
//
// Parameters:
//   DWELL     : cycles per vector period (2..255)
//   SETTLE    : cycles a vector is applied before its outputs are checked
//               (1..DWELL-1)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clr       in   synchronous clear to 0 (has priority over en)
//   en        in   count enable
//   at_settle out  counter is on the last settle cycle (cnt == SETTLE-1);
//                  the check cycle follows on the next clock
//   at_end    out  counter is on the last cycle of the period (cnt == DWELL-1)
// -----------------------------------------------------------------------------
module and_sweep_cnt
    import and_sweep_pkg::*;
#(
    parameter int DWELL  = 4,
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic at_settle,
    output logic at_end
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            // Wrapping here is what returns cnt to 0 when the sequencer
            // moves on to the next vector.
            if (cnt == DWELL_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign at_settle = (cnt == SETTLE_LAST);
    assign at_end    = (cnt == DWELL_LAST);

endmodule

// File: rtl/and_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// and_sweep_ctrl
//
// Clocked, self-checking sweep sequencer for the four-input AND datapath
// (E = A&B, F = C&D, G = A&B&C&D). On start it drives all 16 vectors in
// binary order, each for DWELL cycles, checks E/F/G once per vector SETTLE
// cycles after the vector is applied, and reports the mismatch count and a
// pass flag.
//
// Parameters:
//   DWELL  : cycles each vector is held (2..255)
//   SETTLE : cycles from vector application to the check (1..DWELL-1)
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   level-sampled; begins a sweep when idle
//   abort          in   cancels a running sweep (wins over start when idle)
//   dut_e/f/g      in   datapath outputs under test
//   dut_a/b/c/d    out  datapath inputs = vec_idx[3], [2], [1], [0]
//   vec_idx        out  current vector index
//   busy           out  sweep in progress
//   done           out  one-cycle pulse when a sweep completes
//   pass           out  last completed sweep had zero mismatches
//   err_cnt        out  mismatches in the current/last sweep (0..16)
//
// Optional feature, enabled by defining FAIL_CAPTURE_EN:
//   first_fail_vld out  a mismatch has been captured in this sweep
//   first_fail_vec out  vector index of the first mismatch
//   first_fail_efg out  observed {E,F,G} at the first mismatch
//
// Handshake: start/abort are plain levels sampled on every rising edge; there
// is no acknowledge. busy high means start is ignored, done pulses for exactly
// one cycle and is never produced by an abort or a reset.
// -----------------------------------------------------------------------------
module and_sweep_ctrl
    import and_sweep_pkg::*;
#(
    parameter int DWELL  = 4,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_e,
    input  logic             dut_f,
    input  logic             dut_g,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_c,
    output logic             dut_d,
    output logic [VEC_W-1:0] vec_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
`ifdef FAIL_CAPTURE_EN
    ,
    output logic             first_fail_vld,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic [2:0]       first_fail_efg
`endif
);

    state_t     state;
    state_t     state_nxt;

    logic       at_settle;
    logic       at_end;
    logic       last_vec;

    // Control strobes produced by the output decode
    logic       accept;      // start taken in IDLE
    logic       abort_hit;   // abort taken while busy
    logic       check_en;    // this is the compare cycle of a vector
    logic       advance;     // move on to the next vector
    logic       finish;      // last vector done, enter DONE
    logic       cnt_clr;
    logic       cnt_en;

    logic [2:0] obs_efg;
    logic       mismatch;
    logic       err_inc;

    // ------------------------------------------------------------------
    // Dwell counter
    // ------------------------------------------------------------------
    and_sweep_cnt #(
        .DWELL  (DWELL),
        .SETTLE (SETTLE)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .at_settle (at_settle),
        .at_end    (at_end)
    );

    assign cnt_clr = accept | abort_hit;
    assign cnt_en  = busy & ~abort_hit;

    assign last_vec = (vec_idx == LAST_VEC);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // CHECK can also be the last cycle of the period (SETTLE == DWELL-1);
    // at_end is then already true there and HOLD is skipped.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = APPLY;
                end
            end
            APPLY: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (at_settle) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (at_end) begin
                    state_nxt = last_vec ? DONE : APPLY;
                end else begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (at_end) begin
                    state_nxt = last_vec ? DONE : APPLY;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        abort_hit = 1'b0;
        check_en  = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                accept = start & ~abort;
            end
            APPLY: begin
                busy      = 1'b1;
                abort_hit = abort;
            end
            CHECK: begin
                busy      = 1'b1;
                abort_hit = abort;
                check_en  = ~abort;
                advance   = ~abort & at_end & ~last_vec;
                finish    = ~abort & at_end & last_vec;
            end
            HOLD: begin
                busy      = 1'b1;
                abort_hit = abort;
                advance   = ~abort & at_end & ~last_vec;
                finish    = ~abort & at_end & last_vec;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scoreboard: compare observed outputs with the golden function.
    // Any bit difference counts as a single error for the vector.
    // ------------------------------------------------------------------
    assign obs_efg  = {dut_e, dut_f, dut_g};
    assign mismatch = (obs_efg != exp_efg(vec_idx));
    assign err_inc  = check_en & mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_idx <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
        end else if (accept) begin
            vec_idx <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
        end else if (abort_hit) begin
            // err_cnt keeps the partial count for post-mortem.
            vec_idx <= '0;
            pass    <= 1'b0;
        end else begin
            if (err_inc) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (advance) begin
                vec_idx <= vec_idx + 1'b1;
            end
            if (finish) begin
                vec_idx <= '0;
                // The final compare may land on this same edge.
                pass    <= (err_cnt == '0) && !err_inc;
            end
        end
    end

    // Vector bit 3 drives A down to bit 0 driving D.
    assign dut_a = vec_idx[3];
    assign dut_b = vec_idx[2];
    assign dut_c = vec_idx[1];
    assign dut_d = vec_idx[0];

`ifdef FAIL_CAPTURE_EN
    // ------------------------------------------------------------------
    // First-failure capture: latched once per sweep, held through DONE,
    // IDLE and abort, cleared only by reset or an accepted start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
            first_fail_efg <= '0;
        end else if (accept) begin
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
            first_fail_efg <= '0;
        end else if (err_inc && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_vec <= vec_idx;
            first_fail_efg <= obs_efg;
        end
    end
`endif

endmodule

// File: tb/tb_and_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_and_sweep_ctrl
//
// Directed bench for and_sweep_ctrl. A behavioural AND datapath (with
// injectable stuck-at faults) closes the loop around the default instance
// (DWELL=4, SETTLE=2); a second instance with DWELL=2, SETTLE=1 covers the
// no-HOLD path. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_and_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       dut_e, dut_f, dut_g;
    logic       dut_a, dut_b, dut_c, dut_d;
    logic [3:0] vec_idx;
    logic       busy, done, pass;
    logic [4:0] err_cnt;
`ifdef FAIL_CAPTURE_EN
    logic       ff_vld;
    logic [3:0] ff_vec;
    logic [2:0] ff_efg;
    logic       ff2_vld;
    logic [3:0] ff2_vec;
    logic [2:0] ff2_efg;
`endif

    logic       start2;
    logic       abort2;
    logic       e2, f2, g2;
    logic       a2, b2, c2, d2;
    logic [3:0] vec_idx2;
    logic       busy2, done2, pass2;
    logic [4:0] err_cnt2;

    logic       fault_e1;
    logic       fault_g0;

    int n_cmp;
    int n_bad;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- datapath models ----------------
    assign dut_e = fault_e1 ? 1'b1 : (dut_a & dut_b);
    assign dut_f = dut_c & dut_d;
    assign dut_g = fault_g0 ? 1'b0 : (dut_a & dut_b & dut_c & dut_d);

    assign e2 = a2 & b2;
    assign f2 = c2 & d2;
    assign g2 = a2 & b2 & c2 & d2;

    // ---------------- DUTs ----------------
    and_sweep_ctrl #(.DWELL(4), .SETTLE(2)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .dut_e   (dut_e),
        .dut_f   (dut_f),
        .dut_g   (dut_g),
        .dut_a   (dut_a),
        .dut_b   (dut_b),
        .dut_c   (dut_c),
        .dut_d   (dut_d),
        .vec_idx (vec_idx),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt)
`ifdef FAIL_CAPTURE_EN
        ,
        .first_fail_vld (ff_vld),
        .first_fail_vec (ff_vec),
        .first_fail_efg (ff_efg)
`endif
    );

    and_sweep_ctrl #(.DWELL(2), .SETTLE(1)) u_dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start2),
        .abort   (abort2),
        .dut_e   (e2),
        .dut_f   (f2),
        .dut_g   (g2),
        .dut_a   (a2),
        .dut_b   (b2),
        .dut_c   (c2),
        .dut_d   (d2),
        .vec_idx (vec_idx2),
        .busy    (busy2),
        .done    (done2),
        .pass    (pass2),
        .err_cnt (err_cnt2)
`ifdef FAIL_CAPTURE_EN
        ,
        .first_fail_vld (ff2_vld),
        .first_fail_vec (ff2_vec),
        .first_fail_efg (ff2_efg)
`endif
    );

    // ---------------- driver tasks ----------------
    // Leaves the bench at the falling edge right after the accepting edge.
    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples from the current falling edge; returns busy samples seen before
    // done and the sample index of done (-1 if the bound expired).
    task automatic wait_done(output int busy_n, output int done_k);
        busy_n = 0;
        done_k = -1;
        for (int k = 0; k < 200; k++) begin
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        fault_e1 = 1'b0; fault_g0 = 1'b0;
        start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        rst_n = 1'b0;
        #12;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL reset_pass: got %b want 0", pass); end
        n_cmp++; if (err_cnt !== 5'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        n_cmp++; if (vec_idx !== 4'd0) begin n_bad++; $display("FAIL reset_vec_idx: got %0d want 0", vec_idx); end
        n_cmp++; if ({dut_a, dut_b, dut_c, dut_d} !== 4'b0000) begin n_bad++; $display("FAIL reset_abcd: got %b want 0000", {dut_a, dut_b, dut_c, dut_d}); end
        n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL reset_busy2: got %b want 0", busy2); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_normal;
        int bad_trace;
        bad_trace = 0;
        pulse_start;
        for (int k = 0; k < 64; k++) begin
            logic [3:0] ev;
            ev = 4'(k / 4);
            if (busy !== 1'b1 || done !== 1'b0 || vec_idx !== ev ||
                {dut_a, dut_b, dut_c, dut_d} !== ev) bad_trace++;
            @(negedge clk);
        end
        n_cmp++; if (bad_trace != 0) begin n_bad++; $display("FAIL normal_trace: got %0d bad cycles want 0", bad_trace); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL normal_done: got %b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL normal_busy_end: got %b want 0", busy); end
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL normal_pass: got %b want 1", pass); end
        n_cmp++; if (err_cnt !== 5'd0) begin n_bad++; $display("FAIL normal_err_cnt: got %0d want 0", err_cnt); end
        n_cmp++; if ({vec_idx, dut_a, dut_b, dut_c, dut_d} !== 8'h00) begin n_bad++; $display("FAIL normal_vec_end: got %h want 00", {vec_idx, dut_a, dut_b, dut_c, dut_d}); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL normal_done_pulse: got %b want 0", done); end
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL normal_pass_hold: got %b want 1", pass); end
    endtask

    task automatic test_g_stuck;
        int busy_n, done_k;
        fault_g0 = 1'b1;
        pulse_start;
        wait_done(busy_n, done_k);
        n_cmp++; if (done_k != 64) begin n_bad++; $display("FAIL gstuck_done_k: got %0d want 64", done_k); end
        n_cmp++; if (err_cnt !== 5'd1) begin n_bad++; $display("FAIL gstuck_err_cnt: got %0d want 1", err_cnt); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL gstuck_pass: got %b want 0", pass); end
`ifdef FAIL_CAPTURE_EN
        n_cmp++; if (ff_vld !== 1'b1) begin n_bad++; $display("FAIL gstuck_ff_vld: got %b want 1", ff_vld); end
        n_cmp++; if (ff_vec !== 4'd15) begin n_bad++; $display("FAIL gstuck_ff_vec: got %0d want 15", ff_vec); end
        n_cmp++; if (ff_efg !== 3'b110) begin n_bad++; $display("FAIL gstuck_ff_efg: got %b want 110", ff_efg); end
`endif
        fault_g0 = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (err_cnt !== 5'd1) begin n_bad++; $display("FAIL gstuck_err_hold: got %0d want 1", err_cnt); end
    endtask

    task automatic test_e_stuck;
        int busy_n, done_k;
        fault_e1 = 1'b1;
        pulse_start;
        n_cmp++; if (err_cnt !== 5'd0) begin n_bad++; $display("FAIL estuck_err_clear: got %0d want 0", err_cnt); end
`ifdef FAIL_CAPTURE_EN
        n_cmp++; if (ff_vld !== 1'b0) begin n_bad++; $display("FAIL estuck_ff_clear: got %b want 0", ff_vld); end
`endif
        wait_done(busy_n, done_k);
        n_cmp++; if (busy_n != 64) begin n_bad++; $display("FAIL estuck_busy_len: got %0d want 64", busy_n); end
        n_cmp++; if (err_cnt !== 5'd12) begin n_bad++; $display("FAIL estuck_err_cnt: got %0d want 12", err_cnt); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL estuck_pass: got %b want 0", pass); end
`ifdef FAIL_CAPTURE_EN
        n_cmp++; if (ff_vec !== 4'd0) begin n_bad++; $display("FAIL estuck_ff_vec: got %0d want 0", ff_vec); end
        n_cmp++; if (ff_efg !== 3'b100) begin n_bad++; $display("FAIL estuck_ff_efg: got %b want 100", ff_efg); end
`endif
        fault_e1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort;
        int busy_n, done_k, k5, done_seen;
        fault_e1 = 1'b1;
        pulse_start;
        k5 = -1;
        for (int k = 0; k < 100; k++) begin
            if (vec_idx === 4'd5) begin k5 = k; break; end
            @(negedge clk);
        end
        n_cmp++; if (k5 != 20) begin n_bad++; $display("FAIL abort_reach_vec5: got %0d want 20", k5); end
        // vectors 0..4 have been checked with E stuck high
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if ({vec_idx, dut_a, dut_b, dut_c, dut_d} !== 8'h00) begin n_bad++; $display("FAIL abort_vec: got %h want 00", {vec_idx, dut_a, dut_b, dut_c, dut_d}); end
        n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL abort_pass: got %b want 0", pass); end
        n_cmp++; if (err_cnt !== 5'd5) begin n_bad++; $display("FAIL abort_err_cnt: got %0d want 5", err_cnt); end
        done_seen = 0;
        for (int k = 0; k < 70; k++) begin
            if (done === 1'b1 || busy === 1'b1) done_seen++;
            @(negedge clk);
        end
        n_cmp++; if (done_seen != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d active cycles want 0", done_seen); end
        fault_e1 = 1'b0;
        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_wins_busy: got %b want 0", busy); end
        n_cmp++; if (err_cnt !== 5'd5) begin n_bad++; $display("FAIL abort_wins_err: got %0d want 5", err_cnt); end
        pulse_start;
        n_cmp++; if (err_cnt !== 5'd0) begin n_bad++; $display("FAIL abort_restart_err: got %0d want 0", err_cnt); end
        wait_done(busy_n, done_k);
        n_cmp++; if (busy_n != 64 || done_k != 64) begin n_bad++; $display("FAIL abort_restart_len: got busy %0d done %0d want 64 64", busy_n, done_k); end
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL abort_restart_pass: got %b want 1", pass); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        int busy_n, done_k, active;
        pulse_start;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(busy_n, done_k);
        n_cmp++; if (done_k != 43 || busy_n != 43) begin n_bad++; $display("FAIL restart_ignored: got busy %0d done %0d want 43 43", busy_n, done_k); end
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL restart_pass: got %b want 1", pass); end
        @(negedge clk);
        // asynchronous reset mid-sweep
        pulse_start;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL async_rst_busy_done: got %b%b want 00", busy, done); end
        n_cmp++; if ({vec_idx, dut_a, dut_b, dut_c, dut_d} !== 8'h00) begin n_bad++; $display("FAIL async_rst_vec: got %h want 00", {vec_idx, dut_a, dut_b, dut_c, dut_d}); end
        n_cmp++; if (pass !== 1'b0 || err_cnt !== 5'd0) begin n_bad++; $display("FAIL async_rst_pass_err: got %b/%0d want 0/0", pass, err_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        active = 0;
        for (int k = 0; k < 80; k++) begin
            if (done === 1'b1 || busy === 1'b1) active++;
            @(negedge clk);
        end
        n_cmp++; if (active != 0) begin n_bad++; $display("FAIL async_rst_no_done: got %0d active cycles want 0", active); end
    endtask

    task automatic test_back_to_back;
        int busy_n, done_k;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        wait_done(busy_n, done_k);
        n_cmp++; if (done_k != 64) begin n_bad++; $display("FAIL b2b_first_done: got %0d want 64", done_k); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_gap: got %b want 0", busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || vec_idx !== 4'd0) begin n_bad++; $display("FAIL b2b_restart: got busy %b vec %0d want 1 0", busy, vec_idx); end
        start = 1'b0;
        wait_done(busy_n, done_k);
        n_cmp++; if (done_k != 64 || pass !== 1'b1) begin n_bad++; $display("FAIL b2b_second: got done %0d pass %b want 64 1", done_k, pass); end
        @(negedge clk);
    endtask

    task automatic test_dwell2;
        int busy_n, done_k, bad_trace;
        busy_n = 0; done_k = -1; bad_trace = 0;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done2 === 1'b1) begin done_k = k; break; end
            if (busy2 === 1'b1) busy_n++;
            if (k < 32 && vec_idx2 !== 4'(k / 2)) bad_trace++;
            @(negedge clk);
        end
        n_cmp++; if (busy_n != 32 || done_k != 32) begin n_bad++; $display("FAIL dwell2_len: got busy %0d done %0d want 32 32", busy_n, done_k); end
        n_cmp++; if (bad_trace != 0) begin n_bad++; $display("FAIL dwell2_trace: got %0d bad cycles want 0", bad_trace); end
        n_cmp++; if (pass2 !== 1'b1 || err_cnt2 !== 5'd0) begin n_bad++; $display("FAIL dwell2_result: got pass %b err %0d want 1 0", pass2, err_cnt2); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset;
        test_normal;
        test_g_stuck;
        test_e_stuck;
        test_abort;
        test_start_ignored;
        test_back_to_back;
        test_dwell2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
